dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the word-addressed data memory (combinational read, synchronous write, address[1:0] ignored by the memory).
- Port A is the core load/store unit; port B is the debug/DMA master.
- Round-robin arbitration, one transaction at a time, valid/ready request and response handshakes per port.
- Misaligned accesses are rejected here and never reach the memory.

Parameters:
N, 32, data and address width; must match the memory word width.
RR_RESET_LAST, 1, value of the last-grant register after reset (1 = B, so A wins the first tie).

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
a_req_valid  in  1  port A request valid
a_req_ready  out  1  port A request accepted this cycle
a_req_we  in  1  1 = write, 0 = read
a_req_addr  in  N  byte address; must be word aligned
a_req_wdata  in  N  write data
a_rsp_valid  out  1  port A response valid
a_rsp_ready  in  1  port A response consumed
a_rsp_rdata  out  N  read data; 0 for writes and errors
a_rsp_err  out  1  misaligned-address error
b_*  same set of nine ports as a_*, for port B
mem_readEn  out  1  memory read enable
mem_writeEn  out  1  memory write enable
mem_address  out  N  memory address
mem_datain  out  N  memory write data
mem_dataout  in  N  memory read data (combinational)
busy  out  1  high whenever state is not IDLE
owner  out  1  current or last owner (0 = A, 1 = B)

Behaviour:
- State machine: IDLE -> ACCESS -> RESP -> IDLE. Registers: state, own, we_r, addr_r, wdata_r, rdata_r, err_r, last.
- Reset: state=IDLE, last=RR_RESET_LAST, own=RR_RESET_LAST, rdata_r=0, err_r=0.
  - All *_req_ready, *_rsp_valid, mem_readEn, mem_writeEn, busy = 0; mem_address=0, mem_datain=0.
  - While rst=1, every handshake output and mem enable is forced to 0 combinationally, regardless of state.
- IDLE, arbitration (combinational):
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the port that is not `last`.
  - The granted port sees req_ready=1 in the same cycle. The other port's ready stays 0.
  - On the clock edge: latch we/addr/wdata/own, set last=grant, go to ACCESS.
- Requester rule: once asserted, req_valid and its payload stay stable until ready. The arbiter does not check this.
- ACCESS (exactly 1 cycle), aligned case (addr_r[1:0]==0):
  - mem_address=addr_r and mem_datain=wdata_r.
  - Write: mem_writeEn=1, mem_readEn=0.
  - Read: mem_readEn=1, and rdata_r <= mem_dataout at the end of the cycle.
  - err_r <= 0. Go to RESP.
- ACCESS, misaligned case (addr_r[1:0]!=0):
  - mem enables stay 0; err_r <= 1; rdata_r <= 0. Go to RESP.
- mem_address and mem_datain are 0 outside ACCESS.
- RESP:
  - Owner's rsp_valid=1, with rsp_rdata=rdata_r (0 for writes) and rsp_err=err_r.
  - Held until owner rsp_ready=1; then go to IDLE on that edge. No new grant in that cycle.
  - Non-owner rsp_valid=0 and its rsp_rdata=0.
- Latency: accept at cycle t, memory access at t+1, response valid at t+2. Minimum 3 cycles per transaction.
- Read-after-write from either port returns the newly written data, because the write commits at the end of ACCESS.
- Reset mid-operation: the transaction is dropped and no response is issued. A write whose ACCESS cycle coincides with rst=1 is not committed.
- Starvation: with both ports continuously requesting, grants strictly alternate.

Test Plan:
1. After reset, A writes addr 0x10, wdata 0xDEADBEEF -> a_req_ready at t, mem_writeEn=1 with mem_address=0x10 at t+1, a_rsp_valid=1, err=0, rdata=0 at t+2. Then A reads 0x10 -> a_rsp_rdata=0xDEADBEEF.
2. A and B request in the same cycle right after reset -> A granted first, B granted on the next IDLE. Both held valid for 6 transactions -> owners A,B,A,B,A,B.
3. B reads addr 0x13 -> mem_readEn and mem_writeEn stay 0 throughout, b_rsp_err=1, b_rsp_rdata=0.
4. A read with a_rsp_ready=0 for 4 cycles -> a_rsp_valid and rdata held stable, busy=1, and B (valid) gets no ready until 1 cycle after A's response completes.
5. rst asserted during ACCESS of B write 0x55AA55AA to 0x20 -> no commit (a later read of 0x20 returns the prior value), all outputs at reset values the following cycle.
6. B writes 0x8 = 0x12345678 then A reads 0x8 -> A gets 0x12345678, err=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Two-port round-robin arbiter and sequencer in front of a word-addressed data
// memory (combinational read, synchronous write). One transaction is in flight
// at a time and walks IDLE -> ACCESS -> RESP -> IDLE, so each transaction takes
// at least three cycles. Accesses whose byte address is not word aligned are
// rejected with an error response and never reach the memory.
//
// Ports
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   a_req_* / b_req_*             request handshake: valid, ready, we, addr, wdata
//   a_rsp_* / b_rsp_*             response handshake: valid, ready, rdata, err
//   mem_readEn, mem_writeEn       memory enables, asserted only in ACCESS
//   mem_address, mem_datain       memory address / write data, 0 outside ACCESS
//   mem_dataout                   memory read data (combinational)
//   busy                          high whenever a transaction is in flight
//   owner                         current or most recent owner (0 = A, 1 = B)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int   N             = 32,
  parameter logic RR_RESET_LAST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,

  input  logic         a_req_valid,
  output logic         a_req_ready,
  input  logic         a_req_we,
  input  logic [N-1:0] a_req_addr,
  input  logic [N-1:0] a_req_wdata,
  output logic         a_rsp_valid,
  input  logic         a_rsp_ready,
  output logic [N-1:0] a_rsp_rdata,
  output logic         a_rsp_err,

  input  logic         b_req_valid,
  output logic         b_req_ready,
  input  logic         b_req_we,
  input  logic [N-1:0] b_req_addr,
  input  logic [N-1:0] b_req_wdata,
  output logic         b_rsp_valid,
  input  logic         b_rsp_ready,
  output logic [N-1:0] b_rsp_rdata,
  output logic         b_rsp_err,

  output logic         mem_readEn,
  output logic         mem_writeEn,
  output logic [N-1:0] mem_address,
  output logic [N-1:0] mem_datain,
  input  logic [N-1:0] mem_dataout,

  output logic         busy,
  output logic         owner
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic           own_r;
  logic           we_r;
  logic [N-1:0]   addr_r;
  logic [N-1:0]   wdata_r;
  logic [N-1:0]   rdata_r;
  logic           err_r;
  logic           last_r;

  logic           grant_valid_s;
  logic           grant_s;
  logic           aligned_s;

  // The memory ignores address[1:0], so any nonzero low bits mean misaligned.
  function automatic logic is_aligned(input logic [N-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  // Round-robin choice: a lone requester wins, on a tie the port not served last wins.
  always_comb begin
    grant_valid_s = a_req_valid | b_req_valid;
    if (a_req_valid && b_req_valid) begin
      grant_s = ~last_r;
    end else begin
      grant_s = b_req_valid;
    end
    aligned_s = is_aligned(addr_r);
  end

  // Next-state and handshake/memory outputs; everything stays 0 while rst is high.
  always_comb begin
    state_nxt_s = state_r;
    a_req_ready = 1'b0;
    b_req_ready = 1'b0;
    a_rsp_valid = 1'b0;
    b_rsp_valid = 1'b0;
    a_rsp_rdata = {N{1'b0}};
    b_rsp_rdata = {N{1'b0}};
    a_rsp_err   = 1'b0;
    b_rsp_err   = 1'b0;
    mem_readEn  = 1'b0;
    mem_writeEn = 1'b0;
    mem_address = {N{1'b0}};
    mem_datain  = {N{1'b0}};
    busy        = 1'b0;

    if (!rst) begin
      busy = (state_r != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (grant_valid_s) begin
            state_nxt_s = ST_ACCESS;
            if (grant_s) begin
              b_req_ready = 1'b1;
            end else begin
              a_req_ready = 1'b1;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_ACCESS: begin
          state_nxt_s = ST_RESP;
          if (aligned_s) begin
            mem_address = addr_r;
            mem_datain  = wdata_r;
            mem_writeEn = we_r;
            mem_readEn  = ~we_r;
          end else begin
            mem_address = {N{1'b0}};
          end
        end
        ST_RESP: begin
          // Return to IDLE only once the owner takes the response; no grant this cycle.
          if (own_r) begin
            b_rsp_valid = 1'b1;
            b_rsp_rdata = rdata_r;
            b_rsp_err   = err_r;
            if (b_rsp_ready) begin
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s = ST_RESP;
            end
          end else begin
            a_rsp_valid = 1'b1;
            a_rsp_rdata = rdata_r;
            a_rsp_err   = err_r;
            if (a_rsp_ready) begin
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s = ST_RESP;
            end
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = ST_IDLE;
    end
  end

  // State register plus request latch on grant and response capture in ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      last_r  <= RR_RESET_LAST;
      own_r   <= RR_RESET_LAST;
      we_r    <= 1'b0;
      addr_r  <= {N{1'b0}};
      wdata_r <= {N{1'b0}};
      rdata_r <= {N{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (grant_valid_s) begin
            own_r   <= grant_s;
            last_r  <= grant_s;
            we_r    <= grant_s ? b_req_we    : a_req_we;
            addr_r  <= grant_s ? b_req_addr  : a_req_addr;
            wdata_r <= grant_s ? b_req_wdata : a_req_wdata;
          end
        end
        ST_ACCESS: begin
          if (aligned_s) begin
            err_r   <= 1'b0;
            // Writes return zero data; reads capture the combinational memory output.
            rdata_r <= we_r ? {N{1'b0}} : mem_dataout;
          end else begin
            err_r   <= 1'b1;
            rdata_r <= {N{1'b0}};
          end
        end
        default: begin
          err_r <= err_r;
        end
      endcase
    end
  end

  assign owner = own_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a small behavioural data memory.
// Inputs are driven on the falling edge and outputs sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        a_req_valid, a_req_ready, a_req_we;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic        b_req_valid, b_req_ready, b_req_we;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_rsp_rdata;
  logic        mem_readEn, mem_writeEn;
  logic [31:0] mem_address, mem_datain, mem_dataout;
  logic        busy, owner;

  int total;
  int bad;

  logic [31:0] tb_mem [0:63];

  dmem_arbiter #(.N(32), .RR_RESET_LAST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
    .a_rsp_rdata(a_rsp_rdata), .a_rsp_err(a_rsp_err),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
    .b_rsp_rdata(b_rsp_rdata), .b_rsp_err(b_rsp_err),
    .mem_readEn(mem_readEn), .mem_writeEn(mem_writeEn),
    .mem_address(mem_address), .mem_datain(mem_datain), .mem_dataout(mem_dataout),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory: combinational read, write on the rising edge.
  assign mem_dataout = tb_mem[mem_address[7:2]];
  always @(posedge clk) begin
    if (mem_writeEn) tb_mem[mem_address[7:2]] <= mem_datain;
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one transaction on a port and returns the response (bounded waits).
  task automatic run_xact(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err);
    logic got;
    rdata = 32'h0;
    err   = 1'b0;
    @(negedge clk);
    if (port) begin
      b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata;
    end else begin
      a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
    end
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (port ? b_req_ready : a_req_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL xact_grant_timeout port=%0d addr=%h", port, addr);
    end
    @(negedge clk);
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (port ? b_rsp_valid : a_rsp_valid) begin
        got   = 1'b1;
        rdata = port ? b_rsp_rdata : a_rsp_rdata;
        err   = port ? b_rsp_err : a_rsp_err;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL xact_rsp_timeout port=%0d addr=%h", port, addr);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    a_req_valid = 1'b1; a_req_addr = 32'h0; a_req_we = 1'b0;
    b_req_valid = 1'b1; b_req_addr = 32'h0; b_req_we = 1'b0;
    #1;
    total++; if (a_req_ready !== 1'b0 || b_req_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready_forced got a=%b b=%b want 0 0", a_req_ready, b_req_ready);
    end
    @(negedge clk);
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (owner !== 1'b1) begin bad++; $display("FAIL reset_owner got %b want 1", owner); end
    total++; if (mem_readEn !== 1'b0 || mem_writeEn !== 1'b0 || mem_address !== 32'h0 || mem_datain !== 32'h0) begin
      bad++; $display("FAIL reset_mem got re=%b we=%b addr=%h din=%h want 0", mem_readEn, mem_writeEn, mem_address, mem_datain);
    end
    total++; if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_rsp_valid got a=%b b=%b want 0 0", a_rsp_valid, b_rsp_valid);
    end
  endtask

  task automatic test_write_read;
    logic [31:0] rd;
    logic        er;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h10; a_req_wdata = 32'hDEADBEEF;
    #1;
    total++; if (a_req_ready !== 1'b1 || b_req_ready !== 1'b0) begin
      bad++; $display("FAIL wr_accept got a=%b b=%b want 1 0", a_req_ready, b_req_ready);
    end
    @(negedge clk);
    a_req_valid = 1'b0;
    #1;
    total++; if (mem_writeEn !== 1'b1 || mem_readEn !== 1'b0 || mem_address !== 32'h10 || mem_datain !== 32'hDEADBEEF) begin
      bad++; $display("FAIL wr_access got we=%b re=%b addr=%h din=%h want 1 0 00000010 deadbeef", mem_writeEn, mem_readEn, mem_address, mem_datain);
    end
    total++; if (busy !== 1'b1 || owner !== 1'b0) begin
      bad++; $display("FAIL wr_busy_owner got busy=%b owner=%b want 1 0", busy, owner);
    end
    @(negedge clk);
    #1;
    total++; if (a_rsp_valid !== 1'b1 || a_rsp_err !== 1'b0 || a_rsp_rdata !== 32'h0 || b_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL wr_rsp got v=%b err=%b rdata=%h bv=%b want 1 0 0 0", a_rsp_valid, a_rsp_err, a_rsp_rdata, b_rsp_valid);
    end
    run_xact(1'b0, 1'b0, 32'h10, 32'h0, rd, er);
    total++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      bad++; $display("FAIL rd_after_wr got rdata=%h err=%b want deadbeef 0", rd, er);
    end
  endtask

  task automatic test_round_robin;
    logic got, g;
    int   waited;
    do_reset();
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h10;
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 32'h10;
    for (int i = 0; i < 6; i++) begin
      got = 1'b0; waited = 0; g = 1'b0;
      for (int k = 0; k < 10; k++) begin
        #1;
        if (a_req_ready || b_req_ready) begin got = 1'b1; break; end
        waited++;
        @(negedge clk);
      end
      total++; if (!got) begin bad++; $display("FAIL rr_grant_timeout idx=%0d", i); end
      g = b_req_ready;
      total++; if (g !== ((i % 2) == 1)) begin
        bad++; $display("FAIL rr_order idx=%0d got owner %0d want %0d", i, g, i % 2);
      end
      total++; if (a_req_ready && b_req_ready) begin bad++; $display("FAIL rr_dual_ready idx=%0d got both want one", i); end
      if (i > 0) begin
        total++; if (waited !== 0) begin bad++; $display("FAIL rr_period idx=%0d got extra wait %0d want 0", i, waited); end
      end
      @(negedge clk);
      got = 1'b0;
      for (int k = 0; k < 10; k++) begin
        #1;
        if (g ? b_rsp_valid : a_rsp_valid) begin got = 1'b1; break; end
        @(negedge clk);
      end
      total++; if (!got || (g ? b_rsp_rdata : a_rsp_rdata) !== 32'hDEADBEEF) begin
        bad++; $display("FAIL rr_rsp idx=%0d got valid=%b rdata=%h want 1 deadbeef", i, got, g ? b_rsp_rdata : a_rsp_rdata);
      end
      @(negedge clk);
      if (i == 5) begin a_req_valid = 1'b0; b_req_valid = 1'b0; end
    end
  endtask

  task automatic test_misaligned;
    logic saw_en, got;
    saw_en = 1'b0; got = 1'b0;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 32'h13;
    #1;
    total++; if (b_req_ready !== 1'b1) begin bad++; $display("FAIL mis_accept got %b want 1", b_req_ready); end
    @(negedge clk);
    b_req_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (mem_readEn || mem_writeEn) saw_en = 1'b1;
      if (b_rsp_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (saw_en !== 1'b0) begin bad++; $display("FAIL mis_mem_enable got 1 want 0"); end
    total++; if (!got || b_rsp_err !== 1'b1 || b_rsp_rdata !== 32'h0) begin
      bad++; $display("FAIL mis_rsp got valid=%b err=%b rdata=%h want 1 1 0", got, b_rsp_err, b_rsp_rdata);
    end
    total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL mis_other_rsp got %b want 0", a_rsp_valid); end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h10;
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 32'h10;
    #1;
    total++; if (a_req_ready !== 1'b1 || b_req_ready !== 1'b0) begin
      bad++; $display("FAIL bp_grant got a=%b b=%b want 1 0", a_req_ready, b_req_ready);
    end
    @(negedge clk);
    a_req_valid = 1'b0;
    #1;
    total++; if (b_req_ready !== 1'b0 || mem_readEn !== 1'b1) begin
      bad++; $display("FAIL bp_access got bready=%b re=%b want 0 1", b_req_ready, mem_readEn);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      total++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'hDEADBEEF || busy !== 1'b1 || b_req_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d got v=%b rdata=%h busy=%b bready=%b want 1 deadbeef 1 0", c, a_rsp_valid, a_rsp_rdata, busy, b_req_ready);
      end
    end
    @(negedge clk);
    a_rsp_ready = 1'b1;
    #1;
    total++; if (a_rsp_valid !== 1'b1 || b_req_ready !== 1'b0) begin
      bad++; $display("FAIL bp_release got v=%b bready=%b want 1 0", a_rsp_valid, b_req_ready);
    end
    @(negedge clk);
    #1;
    total++; if (a_rsp_valid !== 1'b0 || b_req_ready !== 1'b1) begin
      bad++; $display("FAIL bp_b_grant got av=%b bready=%b want 0 1", a_rsp_valid, b_req_ready);
    end
    @(negedge clk);
    b_req_valid = 1'b0;
    @(negedge clk);
    #1;
    total++; if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 32'hDEADBEEF || owner !== 1'b1) begin
      bad++; $display("FAIL bp_b_rsp got v=%b rdata=%h owner=%b want 1 deadbeef 1", b_rsp_valid, b_rsp_rdata, owner);
    end
  endtask

  task automatic test_reset_midop;
    logic [31:0] rd;
    logic        er;
    logic        leak;
    run_xact(1'b0, 1'b1, 32'h20, 32'h0BADF00D, rd, er);
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 32'h20; b_req_wdata = 32'h55AA55AA;
    #1;
    total++; if (b_req_ready !== 1'b1) begin bad++; $display("FAIL rmid_accept got %b want 1", b_req_ready); end
    @(negedge clk);
    b_req_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (mem_writeEn !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rmid_forced got we=%b busy=%b want 0 0", mem_writeEn, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || owner !== 1'b1 || mem_readEn !== 1'b0 || mem_writeEn !== 1'b0 ||
                 mem_address !== 32'h0 || mem_datain !== 32'h0 || b_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rmid_after got busy=%b owner=%b re=%b we=%b addr=%h din=%h bv=%b want 0 1 0 0 0 0 0",
                      busy, owner, mem_readEn, mem_writeEn, mem_address, mem_datain, b_rsp_valid);
    end
    leak = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      if (b_rsp_valid || busy) leak = 1'b1;
    end
    total++; if (leak !== 1'b0) begin bad++; $display("FAIL rmid_no_rsp got activity want none"); end
    run_xact(1'b0, 1'b0, 32'h20, 32'h0, rd, er);
    total++; if (rd !== 32'h0BADF00D || er !== 1'b0) begin
      bad++; $display("FAIL rmid_no_commit got rdata=%h err=%b want 0badf00d 0", rd, er);
    end
  endtask

  task automatic test_raw_cross_port;
    logic [31:0] rd;
    logic        er;
    run_xact(1'b1, 1'b1, 32'h8, 32'h12345678, rd, er);
    total++; if (rd !== 32'h0 || er !== 1'b0) begin
      bad++; $display("FAIL raw_b_write_rsp got rdata=%h err=%b want 0 0", rd, er);
    end
    run_xact(1'b0, 1'b0, 32'h8, 32'h0, rd, er);
    total++; if (rd !== 32'h12345678 || er !== 1'b0) begin
      bad++; $display("FAIL raw_a_read got rdata=%h err=%b want 12345678 0", rd, er);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = 32'h0; a_req_wdata = 32'h0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 32'h0; b_req_wdata = 32'h0;
    a_rsp_ready = 1'b1;
    b_rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_write_read();
    test_round_robin();
    test_misaligned();
    test_backpressure();
    test_reset_midop();
    test_raw_cross_port();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
